// File: rtl/pipelined_hybrid_adder.sv
// ============================================================================
//  Module      : pipelined_hybrid_adder
//  Description : WIDTH-bit add/sub built from BLOCK-bit CLA slices, one slice
//                per pipeline stage, with a valid/ready handshake.
//  Revision    : 1.0 - initial pipelined release
// ============================================================================
`default_nettype none

module pipelined_hybrid_adder #(
    parameter int WIDTH = 16,
    parameter int BLOCK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf
);

    localparam int STAGES = WIDTH / BLOCK;

    // Returns {carry into slice MSB, carry out, sum slice} in lookahead form.
    function automatic logic [BLOCK+1:0] cla(input logic [BLOCK-1:0] x,
                                             input logic [BLOCK-1:0] y,
                                             input logic             ci);
        logic [BLOCK-1:0] g;
        logic [BLOCK-1:0] p;
        logic [BLOCK:0]   c;
        logic             acc;
        logic             pp;
        g    = x & y;
        p    = x ^ y;
        c    = '0;
        c[0] = ci;
        for (int i = 0; i < BLOCK; i++) begin
            acc = g[i];
            pp  = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                acc = acc | (g[j] & pp);
                pp  = pp & p[j];
            end
            c[i+1] = acc | (pp & ci);
        end
        return {c[BLOCK-1], c[BLOCK], p ^ c[BLOCK-1:0]};
    endfunction

    logic w_adv;
    logic out_valid_q;
    logic [WIDTH-1:0] sum_q;
    logic c_out_q;
    logic ovf_q;

    // Stall is global: every stage, bubbles included, moves or holds together.
    assign w_adv     = !out_valid_q || out_ready;
    assign in_ready  = rst || w_adv;
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign c_out     = c_out_q;
    assign ovf       = ovf_q;

    logic [WIDTH-1:0] w_pa [STAGES];
    logic [WIDTH-1:0] w_pb [STAGES];
    logic [WIDTH-1:0] w_ps [STAGES];
    logic             w_pc [STAGES];
    logic             w_pv [STAGES];

    logic             v0_q;
    logic [WIDTH-1:0] a0_q;
    logic [WIDTH-1:0] b0_q;
    logic             c0_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            v0_q <= 1'b0;
        end else if (w_adv) begin
            v0_q <= in_valid;
            a0_q <= a;
            b0_q <= sub ? ~b : b;
            c0_q <= sub | c_in;
        end
    end

    assign w_pv[0] = v0_q;
    assign w_pa[0] = a0_q;
    assign w_pb[0] = b0_q;
    assign w_pc[0] = c0_q;
    assign w_ps[0] = '0;

    generate
        for (genvar k = 0; k < STAGES; k++) begin : g_stage
            logic [BLOCK+1:0] w_r;
            logic [WIDTH-1:0] s_d;

            assign w_r = cla(w_pa[k][k*BLOCK +: BLOCK], w_pb[k][k*BLOCK +: BLOCK], w_pc[k]);

            always_comb begin
                s_d                    = w_ps[k];
                s_d[k*BLOCK +: BLOCK]  = w_r[BLOCK-1:0];
            end

            if (k < STAGES - 1) begin : g_mid
                logic             v_q;
                logic [WIDTH-1:0] a_q;
                logic [WIDTH-1:0] b_q;
                logic [WIDTH-1:0] s_q;
                logic             c_q;

                always_ff @(posedge clk) begin
                    if (rst) begin
                        v_q <= 1'b0;
                    end else if (w_adv) begin
                        v_q <= w_pv[k];
                        a_q <= w_pa[k];
                        b_q <= w_pb[k];
                        s_q <= s_d;
                        c_q <= w_r[BLOCK];
                    end
                end

                assign w_pv[k+1] = v_q;
                assign w_pa[k+1] = a_q;
                assign w_pb[k+1] = b_q;
                assign w_ps[k+1] = s_q;
                assign w_pc[k+1] = c_q;
            end else begin : g_last
                // Result fields only change when a real transaction lands.
                always_ff @(posedge clk) begin
                    if (rst) begin
                        out_valid_q <= 1'b0;
                        sum_q       <= '0;
                        c_out_q     <= 1'b0;
                        ovf_q       <= 1'b0;
                    end else if (w_adv) begin
                        out_valid_q <= w_pv[k];
                        if (w_pv[k]) begin
                            sum_q   <= s_d;
                            c_out_q <= w_r[BLOCK];
                            ovf_q   <= w_r[BLOCK+1] ^ w_r[BLOCK];
                        end
                    end
                end
            end
        end
    endgenerate

endmodule

`default_nettype wire
